// File: rtl/stack_pkg.sv
// Shared types for the JVM operand stack: op codes and control-FSM states.
// Codes 6 and 7 are deliberately absent; the stack rejects them as illegal.
package stack_pkg;

  typedef enum logic [2:0] {
    NOP  = 3'd0,
    PUSH = 3'd1,
    POP  = 3'd2,
    DUP  = 3'd3,
    SWAP = 3'd4,
    PEEK = 3'd5
  } stack_op_t;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    POP_RD  = 2'd1,
    SWAP_RD = 2'd2
  } stack_state_t;

endpackage

// File: rtl/block_ram.sv
// Simple dual-port RAM: one write port and one synchronous read port, 1-cycle read latency.
// No backpressure; contents are never cleared.
module block_ram #(
  parameter int DATA  = 32,
  parameter int DEPTH = 65536,
  localparam int ADDRW = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             we_i,
  input  logic [ADDRW-1:0] waddr_i,
  input  logic [DATA-1:0]  wdata_i,
  input  logic             re_i,
  input  logic [ADDRW-1:0] raddr_i,
  output logic [DATA-1:0]  rdata_o
);

  logic [DATA-1:0] mem_q [DEPTH];
  logic [DATA-1:0] rdata_q;

  always_ff @(posedge clk) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
    if (re_i) rdata_q <= mem_q[raddr_i];
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/operand_stack.sv
// JVM operand stack with the TOS cached in a register and deeper entries in block_ram.
// PUSH/DUP/PEEK/NOP and rejects complete in 1 cycle, POP/SWAP in 2 (busy=1); triggers while busy are dropped.
module operand_stack
  import stack_pkg::*;
#(
  parameter int DATA  = 32,
  parameter int DEPTH = 65536,
  localparam int ADDRW = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             trigger,
  input  logic [2:0]       op,
  input  logic [DATA-1:0]  writevalue,
  output logic [DATA-1:0]  readvalue,
  output logic [ADDRW:0]   count,
  output logic             empty,
  output logic             full,
  output logic             busy,
  output logic             done,
  output logic             error
);

  localparam logic [ADDRW:0]   CNT_ONE  = (ADDRW+1)'(1);
  localparam logic [ADDRW:0]   CNT_TWO  = (ADDRW+1)'(2);
  localparam logic [ADDRW:0]   CNT_FULL = (ADDRW+1)'(DEPTH);
  localparam logic [ADDRW-1:0] ADR_ONE  = ADDRW'(1);
  localparam logic [ADDRW-1:0] ADR_TWO  = ADDRW'(2);

  stack_state_t   state_q, state_d;
  logic [ADDRW:0] count_q, count_d;
  logic [DATA-1:0] tos_q, tos_d;
  logic           done_q, done_d;
  logic           error_q, error_d;

  logic             ram_we, ram_re;
  logic [ADDRW-1:0] ram_waddr, ram_raddr;
  logic [DATA-1:0]  ram_wdata, ram_rdata;
  logic [ADDRW-1:0] addr_m1, addr_m2;
  logic             empty_w, full_w, reject;

  assign empty_w = (count_q == '0);
  assign full_w  = (count_q == CNT_FULL);
  // Entry count-1 is the TOS register, so the slot just below it is RAM[count-2].
  assign addr_m1 = count_q[ADDRW-1:0] - ADR_ONE;
  assign addr_m2 = count_q[ADDRW-1:0] - ADR_TWO;

  always_comb begin
    state_d   = state_q;
    count_d   = count_q;
    tos_d     = tos_q;
    done_d    = 1'b0;
    error_d   = 1'b0;
    reject    = 1'b0;
    ram_we    = 1'b0;
    ram_re    = 1'b0;
    ram_waddr = addr_m1;
    ram_raddr = addr_m2;
    ram_wdata = tos_q;

    case (state_q)
      IDLE: begin
        if (trigger) begin
          done_d = 1'b1;
          case (op)
            NOP: reject = 1'b0;
            PUSH: begin
              if (full_w) begin
                reject = 1'b1;
              end else begin
                ram_we  = !empty_w;
                tos_d   = writevalue;
                count_d = count_q + CNT_ONE;
              end
            end
            POP: begin
              if (empty_w) begin
                reject = 1'b1;
              end else begin
                ram_re  = 1'b1;
                state_d = POP_RD;
                done_d  = 1'b0;
              end
            end
            DUP: begin
              if (full_w || empty_w) begin
                reject = 1'b1;
              end else begin
                ram_we  = 1'b1;
                count_d = count_q + CNT_ONE;
              end
            end
            SWAP: begin
              if (count_q < CNT_TWO) begin
                reject = 1'b1;
              end else begin
                ram_re  = 1'b1;
                state_d = SWAP_RD;
                done_d  = 1'b0;
              end
            end
            PEEK:    reject = empty_w;
            default: reject = 1'b1;
          endcase
          error_d = reject;
        end
      end
      POP_RD: begin
        // With a single entry the read was a don't-care and the stack simply empties.
        tos_d   = (count_q >= CNT_TWO) ? ram_rdata : '0;
        count_d = count_q - CNT_ONE;
        done_d  = 1'b1;
        state_d = IDLE;
      end
      SWAP_RD: begin
        tos_d     = ram_rdata;
        ram_we    = 1'b1;
        ram_waddr = addr_m2;
        done_d    = 1'b1;
        state_d   = IDLE;
      end
      default: state_d = IDLE;
    endcase

    if (rst) begin
      ram_we = 1'b0;
      ram_re = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      count_q <= '0;
      tos_q   <= '0;
      done_q  <= 1'b0;
      error_q <= 1'b0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      tos_q   <= tos_d;
      done_q  <= done_d;
      error_q <= error_d;
    end
  end

  block_ram #(
    .DATA  (DATA),
    .DEPTH (DEPTH)
  ) u_ram (
    .clk     (clk),
    .we_i    (ram_we),
    .waddr_i (ram_waddr),
    .wdata_i (ram_wdata),
    .re_i    (ram_re),
    .raddr_i (ram_raddr),
    .rdata_o (ram_rdata)
  );

  assign readvalue = tos_q;
  assign count     = count_q;
  assign empty     = empty_w;
  assign full      = full_w;
  assign busy      = (state_q != IDLE);
  assign done      = done_q;
  assign error     = error_q;

endmodule
